status_display_controller: RTL and testbench
============================================

// Module: status_display_controller
// PURPOSE
//   Parametrised VGA 640x480@60 status panel for the greenhouse FPGA. Divides the screen into
//   NUM_MODULES horizontal bands separated by black divider lines and fills each band with a colour
//   decoded from that module's 4-bit status word. Status is snapshotted once per frame, so a band
//   never tears mid-frame. Alarmed modules blink at a frame-counted rate. Contains its own pixel
//   clock divider and VGA timing; drives the board DAC directly.
// PARAMETERS
//   NUM_MODULES   4    number of status bands / status words (1..8)
//   DIV_THICK     10   divider line height in lines (even, < V_ACTIVE/NUM_MODULES)
//   BLINK_FRAMES  30   frames per blink half-period (>=1)
//   H_ACTIVE/H_FP/H_SYNC/H_BP  640/16/96/48   horizontal timing, pixels
//   V_ACTIVE/V_FP/V_SYNC/V_BP  480/10/2/33    vertical timing, lines
// PORTS
//   CLOCK_50       in   1              50 MHz system clock; all logic on posedge
//   RESET          in   1              synchronous, active-high reset
//   MODULE_STATUS  in   4*NUM_MODULES  status word of module k at [4k+3:4k]; asynchronous to frame
//   VGA_CLK        out  1              25 MHz pixel clock (CLOCK_50 / 2)
//   VGA_BLANK_N    out  1              high in active video
//   VGA_HS         out  1              hsync, active low
//   VGA_VS         out  1              vsync, active low
//   VGA_R/G/B      out  8 each         colour; each channel all-0 or all-1
//   FRAME_START    out  1              one CLOCK_50 pulse when status snapshot is taken
// BEHAVIOUR
//   Reset: VGA_CLK=0, VGA_BLANK_N=0, VGA_HS=1, VGA_VS=1, RGB=0, FRAME_START=0; h=v=0;
//     frame counter=0, blink phase=0, all snapshot words=4'b0011 (offline). Reset mid-frame
//     restarts the frame at h=v=0 on the next cycle; no partial-line recovery.
//   Pixel enable: pix_en toggles every CLOCK_50 (0 after reset); VGA_CLK = pix_en register.
//     Counters and all VGA outputs update only on cycles where pix_en=1.
//   Counters: h 0..799 wraps to 0 and increments v; v 0..524 wraps to 0. Both 10 bits.
//   Sync: HS low for h in [656,751]; VS low for v in [490,491]; BLANK_N = (h<640 && v<480).
//   Latency: outputs registered, exactly one pixel (2 CLOCK_50) after the (h,v) that produced them;
//     HS/VS/BLANK_N/RGB share that pipeline so they stay aligned.
//   Bands: BAND_H = V_ACTIVE/NUM_MODULES (integer). Line v is in band k when k*BAND_H <= v <
//     (k+1)*BAND_H; band index by comparator chain, no divider. Lines >= NUM_MODULES*BAND_H: black.
//   Dividers: for k=1..NUM_MODULES-1, v in [k*BAND_H-DIV_THICK/2, k*BAND_H+DIV_THICK/2) is black,
//     full width (defaults: 115-124, 235-244, 355-364).
//   Colour decode of snapshot word s: s[1:0] 00 green(010), 01 yellow(110), 10 red(100),
//     11 blue(001); s[2] reserved, ignored; s[3]=alarm: when blink phase=1 band shows white(111).
//   Blanking: RGB=000 whenever BLANK_N would be 0.
//   Snapshot: on pix_en cycle with h=0, v=480 (first blanking line) all words copy MODULE_STATUS,
//     FRAME_START pulses 1 cycle; same cycle frame counter increments; at BLINK_FRAMES-1 it wraps to
//     0 and blink phase toggles. Status changes at any other time are invisible until next snapshot.
// TESTING
//   Reset then free-run 2 frames -> HS period 1600 CLOCK_50, low 192; VS period 840000, low 3200;
//     BLANK_N high 1280 cycles/line on lines 0-479; VGA_CLK 25 MHz, low first after reset.
//   MODULE_STATUS=16'h3210 -> after 1st FRAME_START: lines 0-114 green, 125-234 yellow,
//     245-354 red, 365-479 blue; lines 115-124/235-244/355-364 RGB=000.
//   Change MODULE_STATUS to 16'h0000 at v=200 mid-frame -> remainder of frame unchanged; next frame
//     all bands green.
//   Status 16'h0008, BLINK_FRAMES=2 -> band 0 green 2 frames, white 2 frames, repeating; others stable.
//   NUM_MODULES=3, DIV_THICK=4 -> BAND_H=160; dividers on lines 158-161 and 318-321; no extra bands.
//   Assert RESET at h=300,v=250 for 1 cycle -> outputs return to reset values, next line starts
//     h=0,v=0, snapshot=offline (blue) until first FRAME_START.

Source files
------------

// File: rtl/status_display_controller.sv
// Status panel on a VGA raster: one coloured band per module status word,
// with black dividers between bands. The status words are latched once per
// frame at the first blanking line, so a band cannot change colour mid-frame.
module status_display_controller #(
    parameter int NUM_MODULES  = 4,
    parameter int DIV_THICK    = 10,
    parameter int BLINK_FRAMES = 30,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET,
    input  logic [4*NUM_MODULES-1:0] MODULE_STATUS,
    output logic                     VGA_CLK,
    output logic                     VGA_BLANK_N,
    output logic                     VGA_HS,
    output logic                     VGA_VS,
    output logic [7:0]               VGA_R,
    output logic [7:0]               VGA_G,
    output logic [7:0]               VGA_B,
    output logic                     FRAME_START
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAND_H   = V_ACTIVE / NUM_MODULES;
    localparam int BAND_END = NUM_MODULES * BAND_H;
    localparam int BW       = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;
    localparam int FCW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic                        r_pix_en;
    logic [9:0]                  r_h, r_v;
    logic [NUM_MODULES-1:0][3:0] r_snap;
    logic [FCW-1:0]              r_frame_cnt;
    logic                        r_blink;
    logic                        r_blank_n, r_hs, r_vs, r_frame_start;
    logic [2:0]                  r_rgb;

    logic          w_active, w_hs_low, w_vs_low, w_snap_now;
    logic          w_in_bands, w_divider;
    logic [BW-1:0] w_band;
    logic [3:0]    w_word;
    logic [2:0]    w_rgb;

    assign w_active   = (r_h < 10'(H_ACTIVE)) && (r_v < 10'(V_ACTIVE));
    assign w_hs_low   = (r_h >= 10'(H_ACTIVE + H_FP)) && (r_h < 10'(H_ACTIVE + H_FP + H_SYNC));
    assign w_vs_low   = (r_v >= 10'(V_ACTIVE + V_FP)) && (r_v < 10'(V_ACTIVE + V_FP + V_SYNC));
    assign w_snap_now = r_pix_en && (r_h == 10'd0) && (r_v == 10'(V_ACTIVE));
    assign w_in_bands = r_v < 10'(BAND_END);
    assign w_word     = r_snap[w_band];

    // Pixel enable: half-rate strobe that doubles as the pixel clock.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) r_pix_en <= 1'b0;
        else       r_pix_en <= ~r_pix_en;
    end

    // Raster position counters, advanced once per pixel.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_pix_en) begin
            if (r_h == 10'(H_TOTAL - 1)) begin
                r_h <= '0;
                r_v <= (r_v == 10'(V_TOTAL - 1)) ? 10'd0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
        end
    end

    // Band index and divider detection via constant-threshold comparators.
    always_comb begin
        w_band    = '0;
        w_divider = 1'b0;
        for (int k = 1; k < NUM_MODULES; k++) begin
            if (r_v >= 10'(k * BAND_H))
                w_band = BW'(k);
            if ((r_v >= 10'(k * BAND_H - DIV_THICK / 2)) && (r_v < 10'(k * BAND_H + DIV_THICK / 2)))
                w_divider = 1'b1;
        end
    end

    // Colour decode of the latched word; black outside bands, on dividers and in blanking.
    always_comb begin
        w_rgb = 3'b000;
        if (w_active && w_in_bands && !w_divider) begin
            if (w_word[3] && r_blink) begin
                w_rgb = 3'b111;
            end else begin
                case (w_word[1:0])
                    2'b00:   w_rgb = 3'b010;
                    2'b01:   w_rgb = 3'b110;
                    2'b10:   w_rgb = 3'b100;
                    default: w_rgb = 3'b001;
                endcase
            end
        end
    end

    // Single output register stage keeps sync, blank and colour aligned.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_blank_n <= 1'b0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_rgb     <= 3'b000;
        end else if (r_pix_en) begin
            r_blank_n <= w_active;
            r_hs      <= ~w_hs_low;
            r_vs      <= ~w_vs_low;
            r_rgb     <= w_rgb;
        end
    end

    // Once-per-frame status latch, frame counter and blink phase.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_frame_start <= 1'b0;
            r_snap        <= {NUM_MODULES{4'b0011}};
            r_frame_cnt   <= '0;
            r_blink       <= 1'b0;
        end else begin
            r_frame_start <= w_snap_now;
            if (w_snap_now) begin
                r_snap <= MODULE_STATUS;
                if (r_frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign VGA_CLK     = r_pix_en;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_R       = {8{r_rgb[2]}};
    assign VGA_G       = {8{r_rgb[1]}};
    assign VGA_B       = {8{r_rgb[0]}};
    assign FRAME_START = r_frame_start;
endmodule

// File: tb/tb_status_display_controller.sv
// Bench for status_display_controller: two instances on a shrunken raster
// (4 bands / 2-line dividers / blink every 2 frames, and 3 bands / 4-line
// dividers / blink every frame) compared every cycle to a frame-level model.
module tb_status_display_controller;
    localparam int HA = 16, HFP = 2, HSY = 4, HBP = 2;
    localparam int VA = 26, VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;       // pixels per frame
    localparam int FC = 2 * FT;        // CLOCK_50 cycles per frame
    localparam int NA = 4, DA = 2, BA = 2;
    localparam int NB = 3, DB = 4, BB = 1;

    logic clk = 1'b0;
    logic RESET;
    logic [4*NA-1:0] ms_a;
    logic [4*NB-1:0] ms_b;

    logic a_clk, a_bn, a_hs, a_vs, a_fs;
    logic [7:0] a_r, a_g, a_b;
    logic b_clk, b_bn, b_hs, b_vs, b_fs;
    logic [7:0] b_r, b_g, b_b;

    int nchk = 0, nerr = 0;
    int e = 0;
    logic [31:0] snap_a, snap_b;

    always #10 clk = ~clk;

    status_display_controller #(
        .NUM_MODULES(NA), .DIV_THICK(DA), .BLINK_FRAMES(BA),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut_a (
        .CLOCK_50(clk), .RESET(RESET), .MODULE_STATUS(ms_a),
        .VGA_CLK(a_clk), .VGA_BLANK_N(a_bn), .VGA_HS(a_hs), .VGA_VS(a_vs),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .FRAME_START(a_fs)
    );

    status_display_controller #(
        .NUM_MODULES(NB), .DIV_THICK(DB), .BLINK_FRAMES(BB),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut_b (
        .CLOCK_50(clk), .RESET(RESET), .MODULE_STATUS(ms_b),
        .VGA_CLK(b_clk), .VGA_BLANK_N(b_bn), .VGA_HS(b_hs), .VGA_VS(b_vs),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .FRAME_START(b_fs)
    );

    // Colour of pixel (h,v) in frame f, from band geometry and the latched words.
    function automatic logic [2:0] exp_rgb(input int nm, input int dt, input int bf,
                                           input int h, input int v, input int f,
                                           input logic [31:0] snap);
        int bh, band, r;
        logic [3:0] w;
        bh = VA / nm;
        if (h >= HA || v >= VA) return 3'b000;
        band = v / bh;
        if (band >= nm) return 3'b000;
        r = v % bh;
        if (band > 0 && r < dt / 2) return 3'b000;
        if (band < nm - 1 && r >= bh - dt / 2) return 3'b000;
        w = snap[band*4 +: 4];
        if (w[3] && ((f / bf) % 2 == 1)) return 3'b111;
        case (w[1:0])
            2'd0:    return 3'b010;
            2'd1:    return 3'b110;
            2'd2:    return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    // Expected {VGA_CLK, BLANK_N, HS, VS, FRAME_START, R, G, B} after edge number ec since reset.
    function automatic logic [28:0] exp_vec(input int ec, input int nm, input int dt,
                                            input int bf, input logic [31:0] snap);
        int n, h, v, f;
        logic bn, hs, vs, fs;
        logic [2:0] c;
        if (ec < 2) return {(ec % 2) == 1, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0};
        n  = ec / 2 - 1;
        h  = n % HT;
        v  = (n / HT) % VT;
        f  = n / FT;
        bn = (h < HA) && (v < VA);
        hs = !((h >= HA + HFP) && (h < HA + HFP + HSY));
        vs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
        fs = (ec % 2 == 0) && (h == 0) && (v == VA);
        c  = exp_rgb(nm, dt, bf, h, v, f, snap);
        return {(ec % 2) == 1, bn, hs, vs, fs, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

    function automatic int cur_v();
        if (e < 2) return 0;
        return ((e / 2 - 1) / HT) % VT;
    endfunction

    // Advance one clock, then compare both instances against the model.
    task automatic tick();
        logic [28:0] ea, eb, oa, ob;
        @(negedge clk);
        if (RESET) begin
            e      = 0;
            snap_a = 32'h0000_3333;
            snap_b = 32'h0000_0333;
            ea     = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0};
            eb     = ea;
        end else begin
            e  = e + 1;
            ea = exp_vec(e, NA, DA, BA, snap_a);
            eb = exp_vec(e, NB, DB, BB, snap_b);
        end
        oa = {a_clk, a_bn, a_hs, a_vs, a_fs, a_r, a_g, a_b};
        ob = {b_clk, b_bn, b_hs, b_vs, b_fs, b_r, b_g, b_b};
        nchk++;
        assert (oa === ea) else begin
            nerr++;
            $error("FAIL inst_a edge=%0d v=%0d got=%h want=%h", e, cur_v(), oa, ea);
        end
        nchk++;
        assert (ob === eb) else begin
            nerr++;
            $error("FAIL inst_b edge=%0d v=%0d got=%h want=%h", e, cur_v(), ob, eb);
        end
        // Status sampled at the snapshot edge is what the next frame shows.
        if (!RESET && ea[24]) snap_a = {16'd0, ms_a};
        if (!RESET && eb[24]) snap_b = {20'd0, ms_b};
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic run_to_line(input int line);
        for (int i = 0; i < FC && cur_v() != line; i++) tick();
    endtask

    initial begin
        RESET = 1'b1;
        ms_a  = 16'h3210;
        ms_b  = 12'h210;
        run(3);
        RESET = 1'b0;

        // Frame 0 shows offline blue, frame 1 shows the 3210 pattern.
        run(2 * FC);

        // Mid-frame change stays invisible until the next snapshot.
        run_to_line(10);
        ms_a = 16'h0000;
        ms_b = 12'h000;
        run(FC + FC / 2);

        // Alarm bit on one band: blink on frame-counted phase.
        ms_a = 16'h0008;
        ms_b = 12'h800;
        run(5 * FC);

        // Random status changes at arbitrary points in the raster.
        for (int i = 0; i < 2 * FC; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                ms_a = 16'($urandom);
                ms_b = 12'($urandom);
            end
            tick();
        end

        // One-cycle reset in mid-frame, then recovery from h=v=0 with offline words.
        run_to_line(14);
        run(17);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        ms_a  = 16'h1221;
        ms_b  = 12'h102;
        run(2 * FC + 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
